submaster_rr_arb: RTL
=====================

SUBMASTER_RR_ARB -- requirements
Module: submaster_rr_arb

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 3, number of requesting submasters (legal range 2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum cycles in WAIT before abort (0 = watchdog disabled).
REQ-003 SHALL have parameter IDX_W, default $clog2(NUM_MASTERS), width of index outputs.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 start  input  NUM_MASTERS  per-master write request, level.
REQ-008 xfer_done  input  NUM_MASTERS  per-master transfer-complete pulse.
REQ-009 grant  output  NUM_MASTERS  one-hot, single-cycle grant pulse.
REQ-010 processing_submaster  output  NUM_MASTERS  one-hot, high while a master owns the channel.
REQ-011 owner_idx  output  IDX_W  index of current or last owner.
REQ-012 busy  output  1  high in GRANT or WAIT.
REQ-013 timeout_err  output  1  single-cycle pulse on watchdog abort.
REQ-014 timeout_idx  output  IDX_W  index of the last aborted master, held until the next abort or reset.

Function
REQ-015 SHALL implement states IDLE, GRANT and WAIT.
REQ-016 In IDLE with start nonzero, SHALL select the winner by round-robin and go to GRANT next cycle; otherwise it stays in IDLE.
REQ-017 Round-robin search SHALL begin at (last_owner+1) mod NUM_MASTERS and wrap; after reset, last_owner = NUM_MASTERS-1 so master 0 has highest priority.
REQ-018 GRANT SHALL last exactly one cycle with grant[owner]=1, then go unconditionally to WAIT; xfer_done is ignored in GRANT.
REQ-019 In WAIT, xfer_done[owner]=1 SHALL move to IDLE next cycle; xfer_done of non-owners is ignored in every state.
REQ-020 Latency: start sampled in cycle t gives grant in t+1; done in cycle d gives IDLE in d+1, and new arbitration may grant in d+2.
REQ-021 processing_submaster[owner] SHALL be 1 in GRANT and WAIT; all bits are 0 in IDLE.
REQ-022 last_owner SHALL update to the winner on the IDLE->GRANT transition.
REQ-023 When TIMEOUT_CYCLES>0, a WAIT cycle counter SHALL clear on entry to WAIT; if it reaches TIMEOUT_CYCLES-1 with no done, the FSM goes to IDLE, pulses timeout_err for one cycle and loads timeout_idx=owner.
REQ-024 If done and timeout occur in the same cycle, done SHALL win and timeout_err stays 0.
REQ-025 The counter SHALL saturate and not wrap; its width is $clog2(TIMEOUT_CYCLES+1).
REQ-026 start deassertion after winning SHALL NOT cancel GRANT or WAIT.
REQ-027 Unused encodings of the state register SHALL return to IDLE.

Reset
REQ-028 On reset SHALL set state=IDLE, grant=0, processing_submaster=0, busy=0, owner_idx=0, timeout_err=0, timeout_idx=0, counter=0 and last_owner=NUM_MASTERS-1.
REQ-029 Reset asserted mid-transfer SHALL abort without pulsing timeout_err; the first grant after reset goes to the lowest-index requester.

Structure
REQ-030 Package submaster_arb_pkg SHALL hold the state enum (IDLE, GRANT, WAIT) and the maximum-masters constant (8).
REQ-031 SHALL instantiate one sub-module rr_pick: combinational request-vector plus pointer in, one-hot winner and index out.

Verification
REQ-032 Single request: N=3, start=3'b010 at t0 -> grant=3'b010 at t0+1, processing_submaster=3'b010 until done+1.
REQ-033 Fairness: start=3'b111 held, done 2 cycles after each grant -> grant order 0,1,2,0.
REQ-034 Wrap: last_owner=2, start=3'b011 -> master 0 granted; then last_owner=0, start=3'b101 -> master 2 granted.
REQ-035 Timeout: TIMEOUT_CYCLES=4, master 1 granted, no done -> timeout_err pulse after 4 WAIT cycles, timeout_idx=1, IDLE next.
REQ-036 Collision: done[owner] on the timeout cycle -> IDLE, timeout_err=0; done of a non-owner during WAIT -> no effect.
REQ-037 Reset in WAIT: all outputs at reset values next cycle; start=3'b110 then grants master 1.

Source files
------------

// File: rtl/submaster_arb_pkg.sv
// Shared types and limits for the submaster round-robin arbiter.
package submaster_arb_pkg;

   localparam int MAX_MASTERS = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      WAIT  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches from (i_ptr+1) mod N upward with
// wrap-around and returns the first requester as one-hot plus index.
module rr_pick
   import submaster_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 3,
   parameter int IDX_W       = $clog2(NUM_MASTERS)
)(
   input  logic [NUM_MASTERS-1:0] i_req,
   input  logic [IDX_W-1:0]       i_ptr,
   output logic [NUM_MASTERS-1:0] o_gnt,
   output logic [IDX_W-1:0]       o_idx
);

   logic [IDX_W-1:0] w_cand;
   logic             w_found;

   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_cand  = '0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         w_cand = IDX_W'((int'(i_ptr) + k) % NUM_MASTERS);
         if (!w_found && i_req[w_cand]) begin
            w_found       = 1'b1;
            o_gnt[w_cand] = 1'b1;
            o_idx         = w_cand;
         end
      end
   end

endmodule

// File: rtl/submaster_rr_arb.sv
// Round-robin arbiter granting one submaster at a time, with a WAIT-state
// watchdog that aborts a transfer whose done pulse never arrives.
module submaster_rr_arb
   import submaster_arb_pkg::*;
#(
   parameter int NUM_MASTERS    = 3,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int IDX_W          = $clog2(NUM_MASTERS)
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_MASTERS-1:0] start,
   input  logic [NUM_MASTERS-1:0] xfer_done,
   output logic [NUM_MASTERS-1:0] grant,
   output logic [NUM_MASTERS-1:0] processing_submaster,
   output logic [IDX_W-1:0]       owner_idx,
   output logic                   busy,
   output logic                   timeout_err,
   output logic [IDX_W-1:0]       timeout_idx
);

   // Width kept at least 1 so the disabled-watchdog build still elaborates.
   localparam int               CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   arb_state_t             r_state;
   logic [NUM_MASTERS-1:0] r_grant;
   logic [NUM_MASTERS-1:0] r_proc;
   logic [IDX_W-1:0]       r_owner;
   logic [IDX_W-1:0]       r_last;
   logic                   r_busy;
   logic                   r_terr;
   logic [IDX_W-1:0]       r_tidx;
   logic [CNT_W-1:0]       r_cnt;

   logic [NUM_MASTERS-1:0] w_win;
   logic [IDX_W-1:0]       w_win_idx;

   rr_pick #(
      .NUM_MASTERS (NUM_MASTERS),
      .IDX_W       (IDX_W)
   ) u_pick (
      .i_req (start),
      .i_ptr (r_last),
      .o_gnt (w_win),
      .o_idx (w_win_idx)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_proc  <= '0;
         r_owner <= '0;
         r_last  <= LAST_RST;
         r_busy  <= 1'b0;
         r_terr  <= 1'b0;
         r_tidx  <= '0;
         r_cnt   <= '0;
      end else begin
         r_grant <= '0;
         r_terr  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (|start) begin
                  r_state <= GRANT;
                  r_grant <= w_win;
                  r_proc  <= w_win;
                  r_owner <= w_win_idx;
                  r_last  <= w_win_idx;
                  r_busy  <= 1'b1;
               end
            end
            GRANT: begin
               r_state <= WAIT;
               r_cnt   <= '0;
            end
            WAIT: begin
               // Owner's done has priority over a watchdog expiry in the same cycle.
               if (xfer_done[r_owner]) begin
                  r_state <= IDLE;
                  r_proc  <= '0;
                  r_busy  <= 1'b0;
               end else if ((TIMEOUT_CYCLES > 0) && (r_cnt == CNT_LAST)) begin
                  r_state <= IDLE;
                  r_proc  <= '0;
                  r_busy  <= 1'b0;
                  r_terr  <= 1'b1;
                  r_tidx  <= r_owner;
               end else begin
                  r_cnt <= sat_inc(r_cnt);
               end
            end
            default: begin
               r_state <= IDLE;
               r_proc  <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign grant                = r_grant;
   assign processing_submaster = r_proc;
   assign owner_idx            = r_owner;
   assign busy                 = r_busy;
   assign timeout_err          = r_terr;
   assign timeout_idx          = r_tidx;

endmodule
